// File: rtl/ui_pkg.sv
// Shared user-interface definitions: button index map, repeat-FSM states and
// small elaboration-time helpers used by the button front end.
package ui_pkg;

    localparam int BTN_ENTER = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;
    localparam int BTN_COUNT = 5;
    localparam int SW_COUNT  = 8;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw pin inputs and conditioned outputs of the button/switch front end.
interface button_conditioner_if
    import ui_pkg::*;
#(
    parameter int NUM_BTN = BTN_COUNT,
    parameter int NUM_SW  = SW_COUNT
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_SW-1:0]  sw_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [NUM_SW-1:0]  sw_sync;
    logic               any_pulse;

    modport master (
        output btn_raw, sw_raw,
        input  btn_level, btn_pulse, sw_sync, any_pulse
    );

    modport slave (
        input  btn_raw, sw_raw,
        output btn_level, btn_pulse, sw_sync, any_pulse
    );
endinterface

// File: rtl/button_conditioner_debounce_ch.sv
// One button channel: 2-flop synchroniser, stable-count debounce and the
// press/auto-repeat event FSM.
module debounce_ch
    import ui_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_PERIOD   = 2700000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic raw_ev
);
    localparam logic RELEASED_VAL = (ACTIVE_LOW != 0);
    localparam int   CW = cnt_w(DEBOUNCE_CYCLES);
    localparam int   RW = cnt_w(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q;
    logic          pressed;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          toggle;
    logic          rise;
    rpt_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // Sync flops reset to the released pin value so a held button re-debounces.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {2{RELEASED_VAL}};
        else       sync_q <= {sync_q[0], raw};
    end

    assign pressed = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
    assign toggle  = (pressed != level_q) && (cnt_q == CNT_LAST);
    assign rise    = toggle && !level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            if (pressed == level_q || toggle) cnt_q <= '0;
            else                              cnt_q <= cnt_q + 1'b1;
            if (toggle) level_q <= ~level_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (rise) begin
            state_d = RPT_DELAY;
            rcnt_d  = '0;
        end else if (!level_q) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                RPT_DELAY: begin
                    if (rcnt_q == DELAY_LAST) begin
                        rcnt_d = '0;
                        if (REPEAT_EN) state_d = RPT_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) rcnt_d = '0;
                    else                       rcnt_d = rcnt_q + 1'b1;
                end
                default: rcnt_d = '0;
            endcase
        end
    end

    // The press event is taken from the toggle decision, so the registered
    // pulse downstream lines up with the level register.
    always_comb begin
        raw_ev = 1'b0;
        if (rise) begin
            raw_ev = 1'b1;
        end else if (level_q) begin
            case (state_q)
                RPT_DELAY:  raw_ev = REPEAT_EN && (rcnt_q == DELAY_LAST);
                RPT_REPEAT: raw_ev = (rcnt_q == PERIOD_LAST);
                default:    raw_ev = 1'b0;
            endcase
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Button/switch front end: per-button debounce channels, switch synchronisers
// and a one-hot priority filter so downstream sees one event per cycle.
module button_conditioner
    import ui_pkg::*;
#(
    parameter int NUM_BTN         = BTN_COUNT,
    parameter int NUM_SW          = SW_COUNT,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_PERIOD   = 2700000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(5'b00110)
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] raw_ev;
    logic [NUM_BTN-1:0] pulse_q;
    logic               any_q;
    logic [NUM_SW-1:0]  sw_meta_q;
    logic [NUM_SW-1:0]  sw_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.btn_raw[i]),
            .level  (level[i]),
            .raw_ev (raw_ev[i])
        );
    end

    // Lowest set bit wins; simultaneous events on other buttons are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= '0;
            any_q   <= 1'b0;
        end else begin
            pulse_q <= raw_ev & (~raw_ev + NUM_BTN'(1));
            any_q   <= |raw_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_q      <= '0;
        end else begin
            sw_meta_q <= bus.sw_raw;
            sw_q      <= sw_meta_q;
        end
    end

    assign bus.btn_level = level;
    assign bus.btn_pulse = pulse_q;
    assign bus.any_pulse = any_q;
    assign bus.sw_sync   = sw_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat constants.
module tb_button_conditioner;
    import ui_pkg::*;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [4:0] IDLE_RAW = 5'b11111;

    typedef struct {
        logic       rst;
        logic [4:0] btn;
        logic [7:0] sw;
        logic [4:0] lvl;
        logic [4:0] pls;
        logic [7:0] sws;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(5), .NUM_SW(8)) bus();

    button_conditioner #(
        .NUM_BTN         (5),
        .NUM_SW          (8),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (5'b00110)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_btn(input string tag, input logic [4:0] lvl, input logic [4:0] pls);
        check({tag, " level"}, 32'(bus.btn_level), 32'(lvl));
        check({tag, " pulse"}, 32'(bus.btn_pulse), 32'(pls));
        check({tag, " any"},   32'(bus.any_pulse), 32'(|pls));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic rst, input logic [4:0] btn, input logic [7:0] sw,
                                input logic [4:0] lvl, input logic [4:0] pls, input logic [7:0] sws);
        vec_t v;
        v.rst = rst; v.btn = btn; v.sw = sw; v.lvl = lvl; v.pls = pls; v.sws = sws;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [4:0] el, ep;

        // Reset state
        for (int k = 0; k < 3; k++) add(1'b1, IDLE_RAW, 8'h00, 5'b0, 5'b0, 8'h00);
        // ENTER held: one press pulse together with the level, no repeats
        for (int k = 1; k <= 20; k++)
            add(1'b0, 5'b11110, 8'h00, (k >= D + 2) ? 5'b00001 : 5'b0,
                (k == D + 2) ? 5'b00001 : 5'b0, 8'h00);
        // ENTER release: level falls after the same latency, no pulse
        for (int k = 1; k <= 8; k++)
            add(1'b0, IDLE_RAW, 8'h00, (k < D + 2) ? 5'b00001 : 5'b0, 5'b0, 8'h00);
        // DOWN glitches: 3 low cycles then 1 high, never accepted
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 3; k++) add(1'b0, 5'b11011, 8'h00, 5'b0, 5'b0, 8'h00);
            add(1'b0, IDLE_RAW, 8'h00, 5'b0, 5'b0, 8'h00);
        end
        for (int k = 0; k < 6; k++) add(1'b0, IDLE_RAW, 8'h00, 5'b0, 5'b0, 8'h00);
        // Switches: two-cycle lag, buttons untouched
        add(1'b0, IDLE_RAW, 8'hA5, 5'b0, 5'b0, 8'h00);
        add(1'b0, IDLE_RAW, 8'hA5, 5'b0, 5'b0, 8'hA5);
        add(1'b0, IDLE_RAW, 8'h5A, 5'b0, 5'b0, 8'hA5);
        add(1'b0, IDLE_RAW, 8'h5A, 5'b0, 5'b0, 8'h5A);
        add(1'b0, IDLE_RAW, 8'h5A, 5'b0, 5'b0, 8'h5A);

        reset = 1'b1;
        bus.btn_raw = IDLE_RAW;
        bus.sw_raw  = 8'h00;
        foreach (tbl[i]) begin
            reset       = tbl[i].rst;
            bus.btn_raw = tbl[i].btn;
            bus.sw_raw  = tbl[i].sw;
            step();
            check_btn($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].pls);
            check($sformatf("vec%0d sw_sync", i), 32'(bus.sw_sync), 32'(tbl[i].sws));
        end

        // UP held: press at D+2, first repeat RD later, then every RP; release after 30
        bus.btn_raw = 5'b11101;
        for (int n = 1; n <= 44; n++) begin
            if (n == 31) bus.btn_raw = IDLE_RAW;
            step();
            el = (n >= D + 2 && n <= 30 + D + 1) ? 5'b00010 : 5'b0;
            ep = ((n == D + 2) || (n >= D + 2 + RD && n <= 34 && ((n - (D + 2 + RD)) % RP) == 0))
                 ? 5'b00010 : 5'b0;
            check_btn($sformatf("up_hold n%0d", n), el, ep);
        end

        // UP and RIGHT together: only UP pulses, RIGHT level still rises
        bus.btn_raw = 5'b01101;
        for (int n = 1; n <= 8; n++) begin
            step();
            check_btn($sformatf("up_right n%0d", n),
                      (n >= D + 2) ? 5'b10010 : 5'b0, (n == D + 2) ? 5'b00010 : 5'b0);
        end
        bus.btn_raw = IDLE_RAW;
        for (int n = 1; n <= 8; n++) begin
            step();
            check_btn($sformatf("up_right_rel n%0d", n), (n < D + 2) ? 5'b10010 : 5'b0, 5'b0);
        end

        // LEFT held through a 2-cycle reset: fresh press pulse afterwards
        bus.btn_raw = 5'b10111;
        for (int n = 1; n <= 8; n++) begin
            step();
            check_btn($sformatf("left n%0d", n),
                      (n >= D + 2) ? 5'b01000 : 5'b0, (n == D + 2) ? 5'b01000 : 5'b0);
        end
        reset = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            step();
            check_btn($sformatf("left_rst n%0d", n), 5'b0, 5'b0);
            check($sformatf("left_rst n%0d sw_sync", n), 32'(bus.sw_sync), 32'h0);
        end
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            check_btn($sformatf("left_post n%0d", n),
                      (n >= D + 2) ? 5'b01000 : 5'b0, (n == D + 2) ? 5'b01000 : 5'b0);
            check($sformatf("left_post n%0d sw_sync", n), 32'(bus.sw_sync),
                  (n >= 2) ? 32'h5A : 32'h0);
        end
        bus.btn_raw = IDLE_RAW;
        for (int n = 0; n < 8; n++) step();
        check_btn("left_final", 5'b0, 5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
